wb_lsu_master_v2: RTL
=====================

# wb_lsu_master_v2

Parametrised Wishbone classic master between the core's load/store unit (LSU) and the system bus. It adds several things the first-generation master lacks: a configurable data width (32 or 64), a registered request and response path, misalignment detection, bus-error (ERR) termination, a watchdog timeout, and signed or unsigned load extension. It accepts one LSU request at a time and drives one single-beat Wishbone cycle per request. It returns exactly one completion pulse carrying load data and an error flag.

## Interface
- DATA_WIDTH, 32, bus and LSU data width; legal values 32 or 64
- ADDR_WIDTH, 32, byte address width
- TIMEOUT_CYCLES, 255, maximum cycles spent in BUS before forced termination; 0 disables the watchdog
- i_CLK  in  1  system clock
- i_RSTN  in  1  reset, asynchronous assert, active-low
- o_ADDR  out  ADDR_WIDTH  Wishbone byte address (full LSU address, unmodified)
- o_DATA  out  DATA_WIDTH  write data, replicated across lanes
- i_DATA  in  DATA_WIDTH  read data
- o_WE  out  1  write enable
- o_SEL  out  DATA_WIDTH/8  byte-lane select
- o_STB, o_CYC  out  1  strobe and cycle
- i_ACK  in  1  normal termination
- i_ERR  in  1  error termination
- i_LSU_REQ  in  1  request; held with attributes stable until o_LSU_GNT
- i_LSU_ADDR  in  ADDR_WIDTH  byte address
- i_LSU_DATA  in  DATA_WIDTH  store data (LSB-aligned)
- i_LSU_WE  in  1  1 = store
- i_LSU_SIZE  in  2  00 byte, 01 half, 10 word, 11 double (64-bit build only)
- i_LSU_UNS  in  1  1 = zero-extend load, 0 = sign-extend
- o_LSU_DATA  out  DATA_WIDTH  registered, extended load data; 0 for stores and errors
- o_LSU_GNT  out  1  one-cycle completion pulse
- o_LSU_ERR  out  1  valid with o_LSU_GNT; 1 = misaligned, bus error or timeout
- o_BUSY  out  1  high in any state other than IDLE

## Operation
- States:
  - IDLE: waits for a request.
  - BUS: Wishbone cycle in progress.
  - RESP: completion cycle.
- IDLE with i_LSU_REQ=1 captures ADDR, SIZE, UNS and WE into internal registers. All later formatting uses these registered copies only.
- Alignment check in IDLE:
  - Legal: half requires addr[0]=0; word requires addr[1:0]=0; double requires addr[2:0]=0.
  - SIZE=11 is illegal when DATA_WIDTH=32.
  - On an illegal request, go IDLE -> RESP with ERR=1. No bus cycle is issued.
- Legal request: go IDLE -> BUS with CYC=STB=1, WE=captured WE, ADDR=i_LSU_ADDR.
  - Lane offset L = addr[log2(DATA_WIDTH/8)-1:0].
  - o_SEL = size mask (1, 3, F, or FF) << L.
  - o_DATA = low 8/16/32/64 bits of store data replicated across the bus. For loads, o_DATA is also driven this way but is don't-care.
- In BUS, the first cycle with i_ACK or i_ERR ends the cycle. If both are high, ERR wins.
- Watchdog:
  - The counter clears on entry to BUS and increments each BUS cycle.
  - When the count equals TIMEOUT_CYCLES-1 with no termination, the master ends the cycle with ERR=1.
- End of cycle (normal or forced): next state is RESP. CYC, STB, WE, SEL, ADDR and DATA all return to 0.
- Load data capture on ACK: o_LSU_DATA = i_DATA >> (8·L), truncated to the access size, then sign- or zero-extended per UNS.
- RESP: o_LSU_GNT=1 for exactly one cycle, then IDLE.
- i_ACK or i_ERR seen outside BUS is ignored.

## Timing
- Reset (async, i_RSTN=0): state IDLE; o_CYC, o_STB, o_WE, o_SEL, o_ADDR, o_DATA, o_LSU_DATA, o_LSU_GNT, o_LSU_ERR and o_BUSY all 0; watchdog 0.
  - Reset asserted mid-cycle drops CYC/STB immediately (asynchronously).
  - No GNT is issued for the aborted request.
- Cycle map:
  - REQ sampled at edge t0 → CYC/STB high from t0+1.
  - ACK sampled at edge tk → CYC/STB low and GNT high from tk+1 → IDLE at tk+2.
  - Minimum latency from request to GNT is 2 cycles (ACK in the first BUS cycle).
  - Misaligned request: GNT with ERR at t0+1.
- i_LSU_REQ still high during the GNT cycle is not a new request. A request held at tk+2 starts a new transaction, so back-to-back throughput is 1 per 3 cycles.
- o_LSU_DATA and o_LSU_ERR hold their values until the next GNT.

## Test plan
- Word load (DW=32): addr 0x100, ACK after 3 wait cycles, i_DATA=0xDEADBEEF → SEL=F during BUS; GNT 1 cycle after ACK; o_LSU_DATA=0xDEADBEEF, ERR=0.
- Byte loads at addr 0x103, i_DATA=0x80123456:
  - UNS=0 → SEL=8, o_LSU_DATA=0xFFFFFF80.
  - UNS=1 → o_LSU_DATA=0x00000080.
- Half store at 0x202, data 0xABCD → SEL=C, o_DATA=0xABCDABCD, WE=1; o_LSU_DATA=0 at GNT.
- Misaligned word load at 0x301 → no CYC ever; GNT+ERR at t0+1. Repeat with SIZE=11 at DW=32 → same.
- ERR with ACK simultaneously → ERR=1. TIMEOUT_CYCLES=4 with no ACK → CYC high exactly 4 cycles, then GNT+ERR.
- DW=64 double load at 0x408, i_DATA=0x0123456789ABCDEF → SEL=FF, o_LSU_DATA=0x0123456789ABCDEF. Separately, drop i_RSTN in the 2nd BUS cycle → CYC=0 immediately, no GNT; the next request completes normally.

Source files
------------

// File: rtl/wb_lsu_master_v2.sv
// Single-beat Wishbone classic master for the LSU. Requests and responses are registered.
// It detects misaligned accesses, handles ERR termination and a watchdog, and extends load data.
module wb_lsu_master_v2 #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    i_CLK,
    input  logic                    i_RSTN,
    output logic [ADDR_WIDTH-1:0]   o_ADDR,
    output logic [DATA_WIDTH-1:0]   o_DATA,
    input  logic [DATA_WIDTH-1:0]   i_DATA,
    output logic                    o_WE,
    output logic [DATA_WIDTH/8-1:0] o_SEL,
    output logic                    o_STB,
    output logic                    o_CYC,
    input  logic                    i_ACK,
    input  logic                    i_ERR,
    input  logic                    i_LSU_REQ,
    input  logic [ADDR_WIDTH-1:0]   i_LSU_ADDR,
    input  logic [DATA_WIDTH-1:0]   i_LSU_DATA,
    input  logic                    i_LSU_WE,
    input  logic [1:0]              i_LSU_SIZE,
    input  logic                    i_LSU_UNS,
    output logic [DATA_WIDTH-1:0]   o_LSU_DATA,
    output logic                    o_LSU_GNT,
    output logic                    o_LSU_ERR,
    output logic                    o_BUSY
);

    localparam int NB  = DATA_WIDTH / 8;
    localparam int LW  = $clog2(NB);
    localparam int WDW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t          state, state_n;
    logic [LW-1:0]   lane_q;
    logic [1:0]      size_q;
    logic            uns_q, we_q;
    logic [WDW-1:0]  wdt;

    logic            legal, timeout, start, reject, done, done_err;
    logic [LW-1:0]   lane_in;
    logic [NB-1:0]   sel_n;
    logic [DATA_WIDTH-1:0] wdata_n, shifted, ext;
    logic            sign;

    assign lane_in = i_LSU_ADDR[LW-1:0];
    assign o_BUSY  = (state != IDLE);
    assign timeout = (TIMEOUT_CYCLES != 0) && (wdt == WDW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        case (i_LSU_SIZE)
            2'b00:   legal = 1'b1;
            2'b01:   legal = ~i_LSU_ADDR[0];
            2'b10:   legal = (i_LSU_ADDR[1:0] == 2'b00);
            default: legal = (DATA_WIDTH == 64) && (i_LSU_ADDR[2:0] == 3'b000);
        endcase
    end

    always_ff @(posedge i_CLK or negedge i_RSTN) begin
        if (!i_RSTN) state <= IDLE;
        else         state <= state_n;
    end

    always_comb begin
        state_n  = state;
        start    = 1'b0;
        reject   = 1'b0;
        done     = 1'b0;
        done_err = 1'b0;
        case (state)
            IDLE: if (i_LSU_REQ) begin
                if (legal) begin
                    start   = 1'b1;
                    state_n = BUS;
                end else begin
                    reject  = 1'b1;
                    state_n = RESP;
                end
            end
            BUS: if (i_ERR || i_ACK || timeout) begin
                // ERR beats ACK; watchdog only matters when neither arrived
                done     = 1'b1;
                done_err = i_ERR || !i_ACK;
                state_n  = RESP;
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Store data replicated per access size; lane mask shifted to the byte offset
    always_comb begin
        wdata_n = '0;
        sel_n   = '0;
        for (int b = 0; b < NB; b++) begin
            wdata_n[b*8 +: 8] = i_LSU_DATA[(b & ((1 << i_LSU_SIZE) - 1))*8 +: 8];
            sel_n[b] = (b >= int'(lane_in)) && (b < int'(lane_in) + (1 << i_LSU_SIZE));
        end
    end

    always_comb begin
        shifted = i_DATA >> {lane_q, 3'b000};
        case (size_q)
            2'b00:   sign = shifted[7];
            2'b01:   sign = shifted[15];
            2'b10:   sign = shifted[31];
            default: sign = shifted[DATA_WIDTH-1];
        endcase
        ext = '0;
        for (int i = 0; i < DATA_WIDTH; i++)
            ext[i] = (i < (8 << size_q)) ? shifted[i] : (sign & ~uns_q);
    end

    always_ff @(posedge i_CLK or negedge i_RSTN) begin
        if (!i_RSTN) begin
            o_ADDR     <= '0;
            o_DATA     <= '0;
            o_SEL      <= '0;
            o_WE       <= 1'b0;
            o_STB      <= 1'b0;
            o_CYC      <= 1'b0;
            o_LSU_DATA <= '0;
            o_LSU_GNT  <= 1'b0;
            o_LSU_ERR  <= 1'b0;
            lane_q     <= '0;
            size_q     <= '0;
            uns_q      <= 1'b0;
            we_q       <= 1'b0;
            wdt        <= '0;
        end else begin
            if (state == IDLE && i_LSU_REQ) begin
                lane_q <= lane_in;
                size_q <= i_LSU_SIZE;
                uns_q  <= i_LSU_UNS;
                we_q   <= i_LSU_WE;
            end
            if (start) begin
                o_CYC  <= 1'b1;
                o_STB  <= 1'b1;
                o_WE   <= i_LSU_WE;
                o_ADDR <= i_LSU_ADDR;
                o_SEL  <= sel_n;
                o_DATA <= wdata_n;
                wdt    <= '0;
            end else if (state == BUS) begin
                wdt <= wdt + 1'b1;
            end
            if (done) begin
                o_CYC      <= 1'b0;
                o_STB      <= 1'b0;
                o_WE       <= 1'b0;
                o_ADDR     <= '0;
                o_SEL      <= '0;
                o_DATA     <= '0;
                o_LSU_GNT  <= 1'b1;
                o_LSU_ERR  <= done_err;
                o_LSU_DATA <= (done_err || we_q) ? '0 : ext;
            end else if (reject) begin
                o_LSU_GNT  <= 1'b1;
                o_LSU_ERR  <= 1'b1;
                o_LSU_DATA <= '0;
            end else begin
                o_LSU_GNT  <= 1'b0;
            end
        end
    end

endmodule
